// File: rtl/mt_pkg.sv
// Shared types and default widths for the mousetrap receive path.
package mt_pkg;

  localparam int DATA_W = 15;
  localparam int ADDR_W = 5;
  localparam int MSG_W  = 10;

  typedef struct packed {
    logic [MSG_W-1:0]  msg;
    logic [ADDR_W-1:0] addr;
  } mt_packet_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } mt_rx_state_e;

endpackage

// File: rtl/mt_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module mt_sync_fifo #(
  parameter int DW    = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                 wr_ptr, rd_ptr;
  logic [DEPTH-1:0][DW-1:0]    mem;
  logic                        do_push, do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mt_sync_rx_sink.sv
// Clocked sink for a 2-phase bundled-data mousetrap port: synchronize req, capture, ack, and
// present packets on a valid/ready stream.
module mt_sync_rx_sink
  import mt_pkg::*;
#(
  parameter int DATA_W      = mt_pkg::DATA_W,
  parameter int ADDR_W      = mt_pkg::ADDR_W,
  parameter int MSG_W       = mt_pkg::MSG_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       rx_count,
  output logic              addr_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s, pending;
  mt_rx_state_e           state;
  logic [DATA_W-1:0]      hold_q;
  logic [ADDR_W-1:0]      addr, addr_m1;
  logic                   addr_ok;
  logic                   push, pop, full, empty;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ ack_out;

  assign addr    = data_in[ADDR_W-1:0];
  assign addr_m1 = addr - ADDR_W'(1);
  assign addr_ok = (addr != '0) && ((addr & addr_m1) == '0);

  // data_in is latched on the same edge ack toggles, while it is still guaranteed stable;
  // the FIFO write follows one cycle later from the holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ack_out  <= 1'b0;
      hold_q   <= '0;
      rx_count <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && !full) begin
            state    <= CAPTURE;
            ack_out  <= ~ack_out;
            hold_q   <= data_in;
            rx_count <= rx_count + 16'd1;
            if (!addr_ok) addr_err <= 1'b1;
          end
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == CAPTURE);
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  mt_sync_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (hold_q),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty)
  );

endmodule
